// File: rtl/chef_life_ctrl.sv
// chef_life_ctrl
// Hit sequencing for the chef: turns the enemy collision level into single
// hits, runs the death / respawn / invulnerability sequence, keeps the lives
// count and latches game-over until a restart request.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   PLAY      | chef controllable, hits are counted
//   DYING     | death animation, chef frozen for DYING_FRAMES frames
//   RESPAWN   | single frame, chef block reloads its start position
//   INVULN    | INVULN_FRAMES frames of blinking, hits ignored
//   GAME_OVER | lives exhausted, waiting for start
module chef_life_ctrl #(
    parameter int LIVES_INIT    = 3,
    parameter int DYING_FRAMES  = 60,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_BIT     = 3
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enemy_hurt,
    input  logic       bonus_life,
    input  logic       start,
    output logic [2:0] lives,
    output logic       chef_freeze,
    output logic       chef_respawn,
    output logic       chef_visible,
    output logic       game_over
);

    typedef enum logic [2:0] {
        PLAY      = 3'd0,
        DYING     = 3'd1,
        RESPAWN   = 3'd2,
        INVULN    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [7:0] DYING_LAST  = 8'(DYING_FRAMES - 1);
    localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
    localparam logic [2:0] LIVES_RST   = 3'(LIVES_INIT);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] lives_q, lives_d;
    logic       hurt_q;
    logic       freeze_q, freeze_d;
    logic       respawn_q, respawn_d;
    logic       visible_q, visible_d;
    logic       over_q, over_d;

    logic       hit;
    logic       dec;
    logic       inc;
    logic       reload;

    // Next-state, lives arithmetic and output decode from the next state.
    always_comb begin
        hit     = enemy_hurt & ~hurt_q;
        state_d = state_q;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        dec     = 1'b0;
        inc     = bonus_life & (state_q != GAME_OVER);
        reload  = 1'b0;

        unique case (state_q)
            PLAY: begin
                if (hit) begin
                    state_d = DYING;
                    cnt_d   = 8'd0;
                    dec     = 1'b1;
                end
            end
            DYING: begin
                if (cnt_q == DYING_LAST) begin
                    state_d = (lives_q == 3'd0) ? GAME_OVER : RESPAWN;
                    cnt_d   = 8'd0;
                end
            end
            RESPAWN: begin
                state_d = INVULN;
                cnt_d   = 8'd0;
            end
            INVULN: begin
                if (cnt_q == INVULN_LAST) begin
                    state_d = PLAY;
                    cnt_d   = 8'd0;
                end
            end
            GAME_OVER: begin
                if (start) begin
                    state_d = RESPAWN;
                    cnt_d   = 8'd0;
                    reload  = 1'b1;
                end
            end
            default: begin
                state_d = PLAY;
                cnt_d   = 8'd0;
            end
        endcase

        // A hit and a bonus in the same frame cancel out.
        if (reload)
            lives_d = LIVES_RST;
        else if (dec && !inc)
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
        else if (inc && !dec)
            lives_d = (lives_q == 3'd7) ? 3'd7 : lives_q + 3'd1;
        else
            lives_d = lives_q;

        freeze_d  = (state_d == DYING) || (state_d == RESPAWN) || (state_d == GAME_OVER);
        respawn_d = (state_d == RESPAWN);
        over_d    = (state_d == GAME_OVER);
        unique case (state_d)
            PLAY, DYING: visible_d = 1'b1;
            INVULN:      visible_d = ~cnt_d[BLINK_BIT];
            default:     visible_d = 1'b0;
        endcase
    end

    // State, counter, lives, edge detector and registered outputs.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q   <= PLAY;
            cnt_q     <= 8'd0;
            lives_q   <= LIVES_RST;
            hurt_q    <= 1'b1;
            freeze_q  <= 1'b0;
            respawn_q <= 1'b0;
            visible_q <= 1'b1;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lives_q   <= lives_d;
            hurt_q    <= enemy_hurt;
            freeze_q  <= freeze_d;
            respawn_q <= respawn_d;
            visible_q <= visible_d;
            over_q    <= over_d;
        end
    end

    assign lives        = lives_q;
    assign chef_freeze  = freeze_q;
    assign chef_respawn = respawn_q;
    assign chef_visible = visible_q;
    assign game_over    = over_q;

endmodule
